// File: rtl/pcihellocore_button_ctrl.sv
// pcihellocore_button_ctrl: debounced push-button port behind the PCIe Avalon bridge.
// Synchronise, debounce per bit, capture presses (W1C) and raise a maskable level irq.
module pcihellocore_button_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    localparam logic [WIDTH-1:0] POL_MASK =
        (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

    // Input path and synchroniser
    logic [WIDTH-1:0] pressed_in;
    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    // Debounce state, one FSM and counter per button
    db_state_e        state_d [WIDTH];
    db_state_e        state_q [WIDTH];
    logic [15:0]      cnt_d   [WIDTH];
    logic [15:0]      cnt_q   [WIDTH];
    logic [WIDTH-1:0] deb_d, deb_q;

    // Host-visible registers
    logic [WIDTH-1:0] edge_d, edge_q;
    logic [WIDTH-1:0] mask_d, mask_q;
    logic             irq_d, irq_q;
    logic [31:0]      rd_d, rd_q;

    // Bus decode helpers
    logic             wr_en;
    logic             mask_wr;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] press;
    logic             unused_wdata;

    assign pressed_in   = in_port ^ POL_MASK;
    assign unused_wdata = ^writedata[31:WIDTH];

    // Two-flop synchroniser; s2 is the RAW view
    always_comb begin
        s1_d = pressed_in;
        s2_d = s1_q;
    end

    // Per-bit debounce: accept a level only after it differs for DEBOUNCE_CYCLES samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_STABLE: begin
                    if (s2_q[i] != deb_q[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = 16'd1;
                    end
                end
                ST_COUNTING: begin
                    if (s2_q[i] == deb_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = 16'd0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        deb_d[i]   = s2_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = 16'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
            endcase
        end
    end

    // Press capture and mask update; a press beats a same-cycle clear
    always_comb begin
        wr_en    = chipselect & write;
        mask_wr  = wr_en && (address == ADDR_MASK);
        edge_clr = (wr_en && (address == ADDR_EDGE)) ?
                   writedata[WIDTH-1:0] : {WIDTH{1'b0}};
        press    = deb_d & ~deb_q;
        edge_d   = (edge_q & ~edge_clr) | press;
        mask_d   = mask_wr ? writedata[WIDTH-1:0] : mask_q;
        irq_d    = |(edge_q & mask_q);
    end

    // Read mux, sampled every cycle into readdata
    always_comb begin
        rd_d = 32'd0;
        unique case (address)
            ADDR_DATA: rd_d[WIDTH-1:0] = deb_q;
            ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
            ADDR_RAW:  rd_d[WIDTH-1:0] = s2_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            deb_q  <= '0;
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
            rd_q   <= 32'd0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= 16'd0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            deb_q  <= deb_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
            rd_q   <= rd_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule
